// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-master peripheral bus arbiter with slave-ack watchdog
// Define BUS_ARB_ROUND_ROBIN_EN for round-robin tie breaking; default is master 0 priority.
module bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] TIMEOUT_DATA   = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_data_i,
    input  logic        m0_read_i,
    input  logic        m0_write_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_data_i,
    input  logic        m1_read_i,
    input  logic        m1_write_i,
    output logic [31:0] m0_data_o,
    output logic        m0_ack_o,
    output logic [31:0] m1_data_o,
    output logic        m1_ack_o,
    output logic [31:0] s_addr_o,
    output logic [31:0] s_data_o,
    output logic        s_read_o,
    output logic        s_write_o,
    input  logic [31:0] s_data_i,
    input  logic        s_ack_i,
    output logic [1:0]  grant_o,
    output logic        err_o
);

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_TOUT} state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [1:0]  r_grant;
    logic [31:0] r_count;
    logic        r_err;
    logic        r_last_grant;

    logic        w_req0;
    logic        w_req1;
    logic        w_tie_pick;
    logic        w_winner;
    logic        w_expire;
    logic        w_sel;

    assign w_req0   = m0_read_i | m0_write_i;
    assign w_req1   = m1_read_i | m1_write_i;
    assign w_expire = (r_count == 32'(TIMEOUT_CYCLES - 1));
    assign w_sel    = r_grant[1];

`ifdef BUS_ARB_ROUND_ROBIN_EN
    assign w_tie_pick = ~r_last_grant;
`else
    // Fixed priority: history is still tracked but never steers a tie.
    assign w_tie_pick = r_last_grant & 1'b0;
`endif

    assign w_winner = (w_req0 & w_req1) ? w_tie_pick : w_req1;

    assign grant_o = r_grant;
    assign err_o   = r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant      <= 2'b00;
            r_count      <= 32'd0;
            r_err        <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req0 | w_req1) begin
                        r_grant      <= w_winner ? 2'b10 : 2'b01;
                        r_last_grant <= w_winner;
                        r_count      <= 32'd0;
                    end
                end
                ST_BUSY: begin
                    if (s_ack_i) begin
                        r_grant <= 2'b00;
                    end else if (w_expire) begin
                        r_err <= 1'b1;
                    end else if (r_count != 32'hFFFF_FFFF) begin
                        r_count <= r_count + 32'd1;
                    end
                end
                ST_TOUT: begin
                    r_grant <= 2'b00;
                end
                default: begin
                    r_grant <= 2'b00;
                end
            endcase
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_req0 | w_req1) w_next_state = ST_BUSY;
            ST_BUSY: begin
                if (s_ack_i) begin
                    w_next_state = ST_IDLE;
                end else if (w_expire) begin
                    w_next_state = ST_TOUT;
                end
            end
            ST_TOUT: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        s_addr_o  = 32'd0;
        s_data_o  = 32'd0;
        s_read_o  = 1'b0;
        s_write_o = 1'b0;
        m0_ack_o  = 1'b0;
        m0_data_o = 32'd0;
        m1_ack_o  = 1'b0;
        m1_data_o = 32'd0;
        case (r_state)
            ST_BUSY: begin
                s_addr_o  = w_sel ? m1_addr_i  : m0_addr_i;
                s_data_o  = w_sel ? m1_data_i  : m0_data_i;
                s_read_o  = w_sel ? m1_read_i  : m0_read_i;
                s_write_o = w_sel ? m1_write_i : m0_write_i;
                if (s_ack_i) begin
                    if (w_sel) begin
                        m1_ack_o  = 1'b1;
                        m1_data_o = s_data_i;
                    end else begin
                        m0_ack_o  = 1'b1;
                        m0_data_o = s_data_i;
                    end
                end
            end
            ST_TOUT: begin
                if (w_sel) begin
                    m1_ack_o  = 1'b1;
                    m1_data_o = TIMEOUT_DATA;
                end else begin
                    m0_ack_o  = 1'b1;
                    m0_data_o = TIMEOUT_DATA;
                end
            end
            default: begin
            end
        endcase
    end

endmodule
